// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one producer at a time for a bounded burst
// and forwards its beats onto the shared fifo_sync write port.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_active,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             grant_active_q, grant_active_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;

    logic [ID_W-1:0]  pick_id;
    int               pick_idx;
    logic             in_grant;
    logic             xfer;
    logic             release_now;

    // Walk from the farthest candidate back to last_grant+1 so the nearest valid one wins.
    always_comb begin
        pick_id  = '0;
        pick_idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pick_idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (req_valid[pick_idx]) begin
                pick_id = ID_W'(pick_idx);
            end
        end
    end

    assign in_grant    = (state_q == GRANT);
    assign xfer        = in_grant && req_valid[grant_id_q] && !fifo_full;
    assign release_now = in_grant &&
                         (!req_valid[grant_id_q] ||
                          (xfer && (req_last[grant_id_q] ||
                                    beat_cnt_q == CNT_W'(MAX_BURST - 1))));

    always_comb begin
        req_ready    = '0;
        fifo_wr_data = '0;
        if (in_grant) begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_wr_data          = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign fifo_wr_en   = xfer;
    assign grant_active = grant_active_q;
    assign grant_id     = grant_id_q;

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        beat_cnt_d     = beat_cnt_q;
        last_grant_d   = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d        = GRANT;
                    grant_id_d     = pick_id;
                    grant_active_d = 1'b1;
                    beat_cnt_d     = '0;
                end
            end
            GRANT: begin
                // A full FIFO simply holds everything; the grant is kept until it drains.
                if (release_now) begin
                    state_d        = IDLE;
                    grant_active_d = 1'b0;
                    last_grant_d   = grant_id_q;
                    beat_cnt_d     = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            beat_cnt_q     <= '0;
            last_grant_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            beat_cnt_q     <= beat_cnt_d;
            last_grant_q   <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus a
// per-cycle reference model, data scoreboard and fairness/burst invariants.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ-1:0]            req_last = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full = 1'b0;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          grant_active;
    logic [1:0]                    grant_id;

    int checks = 0;
    int errors = 0;

    // Each producer sends {id, seq}; seq advances only when the beat is accepted.
    logic [5:0] drv_seq [NUM_REQ];
    logic [5:0] sb_seq  [NUM_REQ];
    logic [NUM_REQ-1:0] acc = '0;

    logic       s_wr, s_act;
    logic [1:0] s_gid;
    logic [3:0] s_ready;

    int order [5] = '{0, 1, 2, 3, 0};

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .grant_active(grant_active),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = {2'(i), drv_seq[i]};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) drv_seq[i] <= drv_seq[i] + 6'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic f);
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        @(negedge clk);
        s_wr    = fifo_wr_en;
        s_act   = grant_active;
        s_gid   = grant_id;
        s_ready = req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic runVec(input string tag, input logic [3:0] v, input logic [3:0] l, input logic f,
                          input logic e_act, input int e_gid, input logic e_wr, input logic [3:0] e_rdy);
        applyStimulus(v, l, f);
        checkOutput({tag, "_active"}, s_act, e_act);
        if (e_act) checkOutput({tag, "_grant_id"}, s_gid, e_gid);
        checkOutput({tag, "_wr_en"}, s_wr, e_wr);
        checkOutput({tag, "_ready"}, s_ready, e_rdy);
    endtask

    // Reference model: who holds the grant, how many beats it has moved, and who was last served.
    int         m_active, m_gid, m_beats, m_last, burst_cnt;
    int         starve [NUM_REQ];
    logic [3:0] prev_valid;
    logic       prev_act;

    always @(negedge clk) begin
        logic [3:0] e_ready;
        logic       e_wr;
        logic [7:0] e_data;
        int         pick;
        acc = req_valid & req_ready;
        if (!rst_n) begin
            m_active   = 0;
            m_gid      = 0;
            m_beats    = 0;
            m_last     = NUM_REQ - 1;
            burst_cnt  = 0;
            prev_act   = 1'b0;
            prev_valid = '0;
            for (int i = 0; i < NUM_REQ; i++) starve[i] = 0;
            checkOutput("rst_active", grant_active, 0);
            checkOutput("rst_wr_en", fifo_wr_en, 0);
            checkOutput("rst_ready", req_ready, 0);
            checkOutput("rst_wr_data", fifo_wr_data, 0);
        end else begin
            e_ready = '0;
            e_wr    = 1'b0;
            e_data  = '0;
            if (m_active != 0) begin
                e_ready = fifo_full ? 4'b0000 : (4'b0001 << m_gid);
                e_wr    = req_valid[m_gid] && !fifo_full;
                e_data  = {2'(m_gid), sb_seq[m_gid]};
            end
            checkOutput("model_active", grant_active, m_active);
            if (m_active != 0) checkOutput("model_grant_id", grant_id, m_gid);
            checkOutput("model_ready", req_ready, e_ready);
            checkOutput("model_wr_en", fifo_wr_en, e_wr);
            checkOutput("model_wr_data", fifo_wr_data, e_data);
            if (fifo_wr_en) checkOutput("wr_while_full", fifo_full, 0);

            if (grant_active && !prev_act) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!prev_valid[i]) starve[i] = 0;
                    else if (i == int'(grant_id)) starve[i] = 0;
                    else begin
                        starve[i]++;
                        checkOutput("starvation_bound", starve[i] < NUM_REQ, 1);
                    end
                end
            end
            if (fifo_wr_en) burst_cnt++;
            if (!grant_active && prev_act) begin
                checkOutput("burst_bound", burst_cnt <= MAX_BURST, 1);
                burst_cnt = 0;
            end

            if (m_active == 0) begin
                if (req_valid != 0) begin
                    pick = -1;
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        if (pick < 0 && req_valid[(m_last + k) % NUM_REQ]) pick = (m_last + k) % NUM_REQ;
                    end
                    m_active = 1;
                    m_gid    = pick;
                    m_beats  = 0;
                end
            end else if (!req_valid[m_gid]) begin
                m_active = 0;
                m_last   = m_gid;
            end else if (!fifo_full) begin
                sb_seq[m_gid] = sb_seq[m_gid] + 6'd1;
                m_beats++;
                if (req_last[m_gid] || m_beats == MAX_BURST) begin
                    m_active = 0;
                    m_last   = m_gid;
                end
            end
            prev_act   = grant_active;
            prev_valid = req_valid;
        end
    end

    initial begin
        int wr_total;
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_seq[i] = '0;
            sb_seq[i]  = '0;
        end

        // Reset state
        repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("reset_active", s_act, 0);
        checkOutput("reset_wr_en", s_wr, 0);
        checkOutput("reset_ready", s_ready, 0);
        checkOutput("reset_grant_id", grant_id, 0);
        checkOutput("reset_wr_data", fifo_wr_data, 0);
        rst_n = 1'b1;

        // All producers requesting: 0,1,2,3,0 with four beats each and an idle cycle between
        wr_total = 0;
        for (int c = 0; c < 25; c++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b0);
            checkOutput("t1_wr_pattern", s_wr, (c % 5) != 0);
            if (c % 5 == 1) checkOutput("t1_grant_order", s_gid, order[c / 5]);
            wr_total += int'(s_wr);
        end
        checkOutput("t1_total_writes", wr_total, 20);

        // Producer 2 alone, last on second beat, then re-granted
        runVec("t2_c0", 4'b0100, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
        runVec("t2_c1", 4'b0100, 4'b0000, 1'b0, 1'b1, 2, 1'b1, 4'b0100);
        runVec("t2_c2", 4'b0100, 4'b0100, 1'b0, 1'b1, 2, 1'b1, 4'b0100);
        runVec("t2_c3", 4'b0100, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
        runVec("t2_c4", 4'b0100, 4'b0000, 1'b0, 1'b1, 2, 1'b1, 4'b0100);
        runVec("t2_c5", 4'b0000, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 4'b0100);
        runVec("t2_c6", 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);

        // Producer 1 stalled by a full FIFO for three cycles mid-burst
        runVec("t3_c0", 4'b0010, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
        runVec("t3_c1", 4'b0010, 4'b0000, 1'b0, 1'b1, 1, 1'b1, 4'b0010);
        runVec("t3_c2", 4'b0010, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 4'b0000);
        runVec("t3_c3", 4'b0010, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 4'b0000);
        runVec("t3_c4", 4'b0010, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 4'b0000);
        runVec("t3_c5", 4'b0010, 4'b0000, 1'b0, 1'b1, 1, 1'b1, 4'b0010);
        runVec("t3_c6", 4'b0010, 4'b0000, 1'b0, 1'b1, 1, 1'b1, 4'b0010);
        runVec("t3_c7", 4'b0010, 4'b0000, 1'b0, 1'b1, 1, 1'b1, 4'b0010);
        runVec("t3_c8", 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);

        // Producer 0 drops valid after one beat; producer 3 must win next
        runVec("t4_c0", 4'b0001, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
        runVec("t4_c1", 4'b1001, 4'b0000, 1'b0, 1'b1, 0, 1'b1, 4'b0001);
        runVec("t4_c2", 4'b1000, 4'b0000, 1'b0, 1'b1, 0, 1'b0, 4'b0001);
        runVec("t4_c3", 4'b1001, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
        runVec("t4_c4", 4'b1001, 4'b0000, 1'b0, 1'b1, 3, 1'b1, 4'b1000);
        runVec("t4_c5", 4'b0000, 4'b0000, 1'b0, 1'b1, 3, 1'b0, 4'b1000);
        runVec("t4_c6", 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);

        // Asynchronous reset after two beats of a burst
        runVec("t5_c0", 4'b0001, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
        runVec("t5_c1", 4'b0001, 4'b0000, 1'b0, 1'b1, 0, 1'b1, 4'b0001);
        runVec("t5_c2", 4'b0001, 4'b0000, 1'b0, 1'b1, 0, 1'b1, 4'b0001);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_active", grant_active, 0);
        checkOutput("t5_async_wr_en", fifo_wr_en, 0);
        checkOutput("t5_async_ready", req_ready, 0);
        checkOutput("t5_async_wr_data", fifo_wr_data, 0);
        checkOutput("t5_async_grant_id", grant_id, 0);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        rst_n = 1'b1;
        runVec("t5_c3", 4'b0100, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);
        runVec("t5_c4", 4'b0100, 4'b0000, 1'b0, 1'b1, 2, 1'b1, 4'b0100);
        runVec("t5_c5", 4'b0000, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 4'b0100);
        runVec("t5_c6", 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000);

        // Random traffic; the model, scoreboard and invariants do the checking
        for (int c = 0; c < 2000; c++) begin
            logic [3:0] v, l;
            for (int i = 0; i < NUM_REQ; i++) begin
                v[i] = ($urandom_range(9, 0) < 7);
                l[i] = ($urandom_range(9, 0) < 3);
            end
            applyStimulus(v, l, $urandom_range(3, 0) == 0);
        end
        repeat (4) applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("final_idle", grant_active, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
